// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel-rate divider, h/v counters and registered sync/blank/strobe decodes.
// Decodes are computed from next-state counters so they stay cycle-aligned with DrawX/DrawY.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       Clk,
  input  logic       Reset_n,
  output logic       pix_ce,
  output logic       pixel_clk,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start,
  output logic       vblank_start
);

  localparam int unsigned HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0] DivHalf = DivW'(CLK_DIV / 2);

  localparam logic [9:0] HLast   = 10'(HTotal - 1);
  localparam logic [9:0] VLast   = 10'(VTotal - 1);
  localparam logic [9:0] HVis    = 10'(H_VISIBLE);
  localparam logic [9:0] VVis    = 10'(V_VISIBLE);
  localparam logic [9:0] HsFirst = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HsLast  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VsFirst = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VsLast  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [DivW-1:0] div_q, div_d;
  logic [9:0]      hc_q, hc_d, vc_q, vc_d;
  logic            hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic            frame_start_q, frame_start_d, vblank_start_q, vblank_start_d;

  always_comb begin
    pix_ce = (div_q == DivLast);
    div_d  = pix_ce ? '0 : div_q + 1'b1;

    hc_d = hc_q;
    vc_d = vc_q;
    if (pix_ce) begin
      // >= keeps the counters in range even if they were somehow disturbed
      if (hc_q >= HLast) begin
        hc_d = '0;
        vc_d = (vc_q >= VLast) ? '0 : vc_q + 10'd1;
      end else begin
        hc_d = hc_q + 10'd1;
      end
    end

    hs_d           = !((hc_d >= HsFirst) && (hc_d <= HsLast));
    vs_d           = !((vc_d >= VsFirst) && (vc_d <= VsLast));
    blank_d        = (hc_d < HVis) && (vc_d < VVis);
    frame_start_d  = pix_ce && (hc_d == '0) && (vc_d == '0);
    vblank_start_d = pix_ce && (hc_d == '0) && (vc_d == VVis);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_q          <= '0;
      hc_q           <= '0;
      vc_q           <= '0;
      hs_q           <= 1'b1;
      vs_q           <= 1'b1;
      blank_q        <= 1'b1;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
    end else begin
      div_q          <= div_d;
      hc_q           <= hc_d;
      vc_q           <= vc_d;
      hs_q           <= hs_d;
      vs_q           <= vs_d;
      blank_q        <= blank_d;
      frame_start_q  <= frame_start_d;
      vblank_start_q <= vblank_start_d;
    end
  end

  // A divide-by-one pixel clock would have to be ~Clk, so it is held high instead.
  if (CLK_DIV == 1) begin : g_pclk_tie
    assign pixel_clk = 1'b1;
  end else begin : g_pclk_div
    assign pixel_clk = (div_q >= DivHalf);
  end

  assign hs           = hs_q;
  assign vs           = vs_q;
  assign blank        = blank_q;
  assign DrawX        = hc_q;
  assign DrawY        = vc_q;
  assign frame_start  = frame_start_q;
  assign vblank_start = vblank_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default 640x480 instance (CLK_DIV=2) and a tiny-raster instance (CLK_DIV=1).
// Positions are derived from the number of Clk edges since reset release.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       m_rst_n, s_rst_n;
  logic       m_pix_ce, m_pclk, m_hs, m_vs, m_blank, m_fs, m_vbs;
  logic [9:0] m_x, m_y;
  logic       s_pix_ce, s_pclk, s_hs, s_vs, s_blank, s_fs, s_vbs;
  logic [9:0] s_x, s_y;

  int checks = 0;
  int errors = 0;
  int m_hs_low = 0, m_vs_low = 0, m_fs_cnt = 0, m_vbs_cnt = 0;
  int s_vs_low = 0, s_fs_cnt = 0, s_vbs_cnt = 0;

  vga_timing_gen u_main (
    .Clk          (clk),
    .Reset_n      (m_rst_n),
    .pix_ce       (m_pix_ce),
    .pixel_clk    (m_pclk),
    .hs           (m_hs),
    .vs           (m_vs),
    .blank        (m_blank),
    .DrawX        (m_x),
    .DrawY        (m_y),
    .frame_start  (m_fs),
    .vblank_start (m_vbs)
  );

  vga_timing_gen #(
    .CLK_DIV   (1),
    .H_VISIBLE (8),
    .H_FRONT   (2),
    .H_SYNC    (2),
    .H_BACK    (2),
    .V_VISIBLE (4),
    .V_FRONT   (1),
    .V_SYNC    (1),
    .V_BACK    (1)
  ) u_small (
    .Clk          (clk),
    .Reset_n      (s_rst_n),
    .pix_ce       (s_pix_ce),
    .pixel_clk    (s_pclk),
    .hs           (s_hs),
    .vs           (s_vs),
    .blank        (s_blank),
    .DrawX        (s_x),
    .DrawY        (s_y),
    .frame_start  (s_fs),
    .vblank_start (s_vbs)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_pos_m(input string tag, input int x, input int y);
    check({tag, " main DrawX"}, 32'(m_x), 32'(x));
    check({tag, " main DrawY"}, 32'(m_y), 32'(y));
  endtask

  task automatic check_pos_s(input string tag, input int x, input int y);
    check({tag, " small DrawX"}, 32'(s_x), 32'(x));
    check({tag, " small DrawY"}, 32'(s_y), 32'(y));
  endtask

  initial begin
    m_rst_n = 1'b0;
    s_rst_n = 1'b0;
    @(posedge clk);
    #1;
    // Reset state
    check_pos_m("rst", 0, 0);
    check("rst main hs", 32'(m_hs), 32'd1);
    check("rst main vs", 32'(m_vs), 32'd1);
    check("rst main blank", 32'(m_blank), 32'd1);
    check("rst main frame_start", 32'(m_fs), 32'd0);
    check("rst main vblank_start", 32'(m_vbs), 32'd0);
    check("rst main pix_ce", 32'(m_pix_ce), 32'd0);
    check("rst main pixel_clk", 32'(m_pclk), 32'd0);
    check_pos_s("rst", 0, 0);
    check("rst small pixel_clk", 32'(s_pclk), 32'd1);
    check("rst small pix_ce", 32'(s_pix_ce), 32'd1);

    @(negedge clk);
    m_rst_n = 1'b1;
    s_rst_n = 1'b1;

    for (int k = 1; k <= 9600; k++) begin
      @(posedge clk);
      #1;
      if (m_hs == 1'b0) m_hs_low++;
      if (m_vs == 1'b0) m_vs_low++;
      if (m_fs) m_fs_cnt++;
      if (m_vbs) m_vbs_cnt++;
      if (s_vs == 1'b0 && k <= 98) s_vs_low++;
      if (s_fs) s_fs_cnt++;
      if (s_vbs) s_vbs_cnt++;

      case (k)
        1: begin
          check_pos_m("e1", 0, 0);
          check("e1 main pix_ce", 32'(m_pix_ce), 32'd1);
          check("e1 main pixel_clk", 32'(m_pclk), 32'd1);
          check("e1 small frame_start", 32'(s_fs), 32'd0);
          check_pos_s("e1", 1, 0);
        end
        2: begin
          check_pos_m("e2", 1, 0);
          check("e2 main pix_ce", 32'(m_pix_ce), 32'd0);
          check("e2 main pixel_clk", 32'(m_pclk), 32'd0);
        end
        3: check("e3 main pix_ce", 32'(m_pix_ce), 32'd1);
        4: begin
          check_pos_m("e4", 2, 0);
          check("e4 main pix_ce", 32'(m_pix_ce), 32'd0);
        end
        7: begin
          check_pos_s("s7", 7, 0);
          check("small blank (7,0)", 32'(s_blank), 32'd1);
        end
        8: check("small blank (8,0)", 32'(s_blank), 32'd0);
        9: begin
          check_pos_s("s9", 9, 0);
          check("small hs hc9", 32'(s_hs), 32'd1);
        end
        10: check("small hs hc10", 32'(s_hs), 32'd0);
        11: check("small hs hc11", 32'(s_hs), 32'd0);
        12: check("small hs hc12", 32'(s_hs), 32'd1);
        13: check("small blank (13,0)", 32'(s_blank), 32'd0);
        14: begin
          check_pos_s("s14", 0, 1);
          check("small blank (0,1)", 32'(s_blank), 32'd1);
        end
        56: begin
          check_pos_s("s56", 0, 4);
          check("small vblank_start (0,4)", 32'(s_vbs), 32'd1);
          check("small blank (0,4)", 32'(s_blank), 32'd0);
        end
        57: check("small vblank_start drop", 32'(s_vbs), 32'd0);
        69: check("small vs (13,4)", 32'(s_vs), 32'd1);
        70: check("small vs (0,5)", 32'(s_vs), 32'd0);
        83: check("small vs (13,5)", 32'(s_vs), 32'd0);
        84: check("small vs (0,6)", 32'(s_vs), 32'd1);
        97: begin
          check_pos_s("s97", 13, 6);
          check("small frame_start pre-wrap", 32'(s_fs), 32'd0);
        end
        98: begin
          check_pos_s("s98", 0, 0);
          check("small frame_start at wrap", 32'(s_fs), 32'd1);
          check("small vs low pixels per frame", 32'(s_vs_low), 32'd14);
        end
        99: check("small frame_start drop", 32'(s_fs), 32'd0);
        1279: begin
          check_pos_m("m1279", 639, 0);
          check("main blank (639,0)", 32'(m_blank), 32'd1);
        end
        1280: begin
          check_pos_m("m1280", 640, 0);
          check("main blank (640,0)", 32'(m_blank), 32'd0);
        end
        1311: begin
          check_pos_m("m1311", 655, 0);
          check("main hs hc655", 32'(m_hs), 32'd1);
        end
        1312: check("main hs hc656", 32'(m_hs), 32'd0);
        1503: begin
          check_pos_m("m1503", 751, 0);
          check("main hs hc751", 32'(m_hs), 32'd0);
        end
        1504: check("main hs hc752", 32'(m_hs), 32'd1);
        1599: begin
          check_pos_m("m1599", 799, 0);
          check("main blank (799,0)", 32'(m_blank), 32'd0);
        end
        1600: begin
          check_pos_m("m1600", 0, 1);
          check("main blank (0,1)", 32'(m_blank), 32'd1);
          check("main hs low clocks line0", 32'(m_hs_low), 32'd192);
        end
        9599: begin
          check_pos_m("m9599", 799, 5);
          check("main pix_ce at (799,5)", 32'(m_pix_ce), 32'd1);
        end
        9600: begin
          check_pos_m("m9600", 0, 6);
          check("main hs after line wrap", 32'(m_hs), 32'd1);
          check("main blank (0,6)", 32'(m_blank), 32'd1);
        end
        default: ;
      endcase
    end

    check("main hs low clocks 6 lines", 32'(m_hs_low), 32'd1152);
    check("main vs low count", 32'(m_vs_low), 32'd0);
    check("main frame_start count", 32'(m_fs_cnt), 32'd0);
    check("main vblank_start count", 32'(m_vbs_cnt), 32'd0);
    check("small frame_start count", 32'(s_fs_cnt), 32'd97);
    check("small vblank_start count", 32'(s_vbs_cnt), 32'd98);

    // Small raster is now at (10,6): hs low and blank low, so reset visibly changes outputs.
    check_pos_s("pre-rst", 10, 6);
    check("pre-rst small hs", 32'(s_hs), 32'd0);
    #3;
    m_rst_n = 1'b0;
    s_rst_n = 1'b0;
    #1;
    check_pos_s("mid-rst", 0, 0);
    check("mid-rst small hs", 32'(s_hs), 32'd1);
    check("mid-rst small vs", 32'(s_vs), 32'd1);
    check("mid-rst small blank", 32'(s_blank), 32'd1);
    check("mid-rst small frame_start", 32'(s_fs), 32'd0);
    check_pos_m("mid-rst", 0, 0);
    check("mid-rst main pixel_clk", 32'(m_pclk), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_pos_s("held-rst", 0, 0);

    @(negedge clk);
    m_rst_n = 1'b1;
    s_rst_n = 1'b1;
    s_fs_cnt = 0;
    for (int j = 1; j <= 100; j++) begin
      @(posedge clk);
      #1;
      if (s_fs) s_fs_cnt++;
      if (j == 2) check_pos_m("restart e2", 1, 0);
      if (j == 97) check("restart small no early frame_start", 32'(s_fs_cnt), 32'd0);
      if (j == 98) check("restart small frame_start", 32'(s_fs), 32'd1);
    end
    check("restart small frame_start count", 32'(s_fs_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
